// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipeline control unit: opcode/funct encodings,
// ALUOp and pc_sel codes, and the per-stage control bundle types.
package ctrl_pkg;

  // Primary opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type function codes (instruction[5:0])
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;

  // ALUOp codes; carried internally at their native width
  localparam int unsigned ALU_OP_BITS = 2;
  localparam logic [ALU_OP_BITS-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALU_OP_BITS-1:0] ALUOP_BR    = 2'b01;
  localparam logic [ALU_OP_BITS-1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [ALU_OP_BITS-1:0] ALUOP_IMM   = 2'b11;

  // Next-PC source select
  localparam int unsigned PC_SEL_W = 2;
  localparam logic [PC_SEL_W-1:0] PC_SEQ    = 2'd0;
  localparam logic [PC_SEL_W-1:0] PC_BRANCH = 2'd1;
  localparam logic [PC_SEL_W-1:0] PC_JUMP   = 2'd2;
  localparam logic [PC_SEL_W-1:0] PC_REG    = 2'd3;

  typedef struct packed {
    logic                   alu_src;
    logic                   reg_dst;
    logic [ALU_OP_BITS-1:0] alu_op;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic ra_write;
  } wb_ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational ID-stage decoder.
// Inputs : i_opcode, i_funct, i_eq (rs==rt)
// Outputs: o_ex/o_mem/o_wb control bundles, o_pc_sel (resolved redirect),
//          o_is_branch (beq/bne), o_is_jreg (jr/jalr),
//          o_is_mult/o_is_mfhilo only when CTRL_MULT_EN is defined.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0]          i_opcode,
  input  logic [5:0]          i_funct,
  input  logic                i_eq,
  output ex_ctrl_t            o_ex,
  output mem_ctrl_t           o_mem,
  output wb_ctrl_t            o_wb,
  output logic [PC_SEL_W-1:0] o_pc_sel,
`ifdef CTRL_MULT_EN
  output logic                o_is_mult,
  output logic                o_is_mfhilo,
`endif
  output logic                o_is_branch,
  output logic                o_is_jreg
);

  always_comb begin
    o_ex        = '0;
    o_mem       = '0;
    o_wb        = '0;
    o_pc_sel    = PC_SEQ;
    o_is_branch = 1'b0;
    o_is_jreg   = 1'b0;
`ifdef CTRL_MULT_EN
    o_is_mult   = 1'b0;
    o_is_mfhilo = 1'b0;
`endif
    case (i_opcode)
      OP_RTYPE: begin
        o_ex.alu_op   = ALUOP_RTYPE;
        o_ex.reg_dst  = 1'b1;
        o_wb.reg_write = 1'b1;
        case (i_funct)
          FN_JR: begin
            o_wb.reg_write = 1'b0;
            o_pc_sel       = PC_REG;
            o_is_jreg      = 1'b1;
          end
          FN_JALR: begin
            o_wb.ra_write = 1'b1;
            o_pc_sel      = PC_REG;
            o_is_jreg     = 1'b1;
          end
`ifdef CTRL_MULT_EN
          // mult writes HI/LO only
          FN_MULT: begin
            o_wb.reg_write = 1'b0;
            o_is_mult      = 1'b1;
          end
          FN_MFHI, FN_MFLO: o_is_mfhilo = 1'b1;
`endif
          default: ;
        endcase
      end
      OP_LW: begin
        o_ex.alu_src      = 1'b1;
        o_ex.alu_op       = ALUOP_ADD;
        o_mem.mem_read    = 1'b1;
        o_wb.mem_to_reg   = 1'b1;
        o_wb.reg_write    = 1'b1;
      end
      OP_SW: begin
        o_ex.alu_src    = 1'b1;
        o_ex.alu_op     = ALUOP_ADD;
        o_mem.mem_write = 1'b1;
      end
      OP_BEQ: begin
        o_ex.alu_op = ALUOP_BR;
        o_is_branch = 1'b1;
        o_pc_sel    = i_eq ? PC_BRANCH : PC_SEQ;
      end
      OP_BNE: begin
        o_ex.alu_op = ALUOP_BR;
        o_is_branch = 1'b1;
        o_pc_sel    = i_eq ? PC_SEQ : PC_BRANCH;
      end
      OP_J: o_pc_sel = PC_JUMP;
      OP_JAL: begin
        o_pc_sel       = PC_JUMP;
        o_wb.ra_write  = 1'b1;
        o_wb.reg_write = 1'b1;
      end
      default: begin
        o_ex.alu_src   = 1'b1;
        o_ex.alu_op    = ALUOP_IMM;
        o_wb.reg_write = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipeline control unit: decodes the ID instruction, carries control through
// ID/EX, EX/MEM and MEM/WB, detects load-use / branch-operand hazards and
// resolves the next-PC select in ID.
// Optional macro CTRL_MULT_EN adds a multiply-busy counter that stalls
// mfhi/mflo and back-to-back mult.
// Ports: clk, rst_n (async active-low); id_* ID-stage fields and comparator;
//        pc_write/ifid_write/if_flush/pc_sel front-end control (combinational);
//        ex_*, mem_*, wb_*, wb_dest registered stage controls.
module ctrl_pipe_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned ALUOP_W = 2,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         id_opcode,
  input  logic [5:0]         id_funct,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               id_eq,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               if_flush,
  output logic [1:0]         pc_sel,
  output logic               ex_alu_src,
  output logic               ex_reg_dst,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               mem_read,
  output logic               mem_write,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg,
  output logic               wb_ra_write,
  output logic [REG_AW-1:0]  wb_dest
);

  localparam int unsigned MUL_CW = 4;

  if (ALUOP_W < 2) begin : g_bad_aluop_w
    $error("ALUOP_W must be at least 2");
  end
  if (MUL_LAT < 2 || MUL_LAT > 15) begin : g_bad_mul_lat
    $error("MUL_LAT must be in 2..15");
  end

  ex_ctrl_t            w_dec_ex;
  mem_ctrl_t           w_dec_mem;
  wb_ctrl_t            w_dec_wb;
  logic [PC_SEL_W-1:0] w_dec_pc_sel;
  logic                w_is_branch;
  logic                w_is_jreg;
  logic [REG_AW-1:0]   w_dest;
  logic                w_stall;
  logic                w_redirect;

  ex_ctrl_t          r_idex_ex;
  mem_ctrl_t         r_idex_mem;
  wb_ctrl_t          r_idex_wb;
  logic [REG_AW-1:0] r_idex_dest;
  mem_ctrl_t         r_exmem_mem;
  wb_ctrl_t          r_exmem_wb;
  logic [REG_AW-1:0] r_exmem_dest;
  wb_ctrl_t          r_memwb_wb;
  logic [REG_AW-1:0] r_memwb_dest;

`ifdef CTRL_MULT_EN
  logic              w_is_mult;
  logic              w_is_mfhilo;
  logic [MUL_CW-1:0] r_mul_cnt;
`endif

  ctrl_decode u_decode (
    .i_opcode    (id_opcode),
    .i_funct     (id_funct),
    .i_eq        (id_eq),
    .o_ex        (w_dec_ex),
    .o_mem       (w_dec_mem),
    .o_wb        (w_dec_wb),
    .o_pc_sel    (w_dec_pc_sel),
`ifdef CTRL_MULT_EN
    .o_is_mult   (w_is_mult),
    .o_is_mfhilo (w_is_mfhilo),
`endif
    .o_is_branch (w_is_branch),
    .o_is_jreg   (w_is_jreg)
  );

  // Writeback destination of the ID instruction
  always_comb begin
    if (w_dec_wb.ra_write)     w_dest = REG_AW'(31);
    else if (w_dec_ex.reg_dst) w_dest = id_rd;
    else                       w_dest = id_rt;
  end

  // Hazard detection; a zero destination never matches
  always_comb begin
    logic ex_wr, ex_ld, mem_ld, ex_rs, ex_rt, mem_rs, mem_rt;
    ex_wr  = r_idex_wb.reg_write   && (r_idex_dest  != '0);
    ex_ld  = r_idex_mem.mem_read   && (r_idex_dest  != '0);
    mem_ld = r_exmem_mem.mem_read  && (r_exmem_dest != '0);
    ex_rs  = (r_idex_dest  == id_rs);
    ex_rt  = (r_idex_dest  == id_rt);
    mem_rs = (r_exmem_dest == id_rs);
    mem_rt = (r_exmem_dest == id_rt);
    w_stall = (ex_ld && (ex_rs || ex_rt))
           || (w_is_branch && ex_wr  && (ex_rs  || ex_rt))
           || (w_is_branch && mem_ld && (mem_rs || mem_rt))
           || (w_is_jreg && ((ex_wr && ex_rs) || (mem_ld && mem_rs)));
`ifdef CTRL_MULT_EN
    if ((r_mul_cnt != '0) && (w_is_mult || w_is_mfhilo)) w_stall = 1'b1;
`endif
  end

  // Redirect is suppressed while stalled and while in reset
  assign w_redirect = rst_n && !w_stall && (w_dec_pc_sel != PC_SEQ);
  assign pc_write   = !w_stall;
  assign ifid_write = !w_stall;
  assign if_flush   = w_redirect;
  assign pc_sel     = w_redirect ? w_dec_pc_sel : PC_SEQ;

  // Stage registers; ID/EX takes a bubble on stall, later stages always advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idex_ex    <= '0;
      r_idex_mem   <= '0;
      r_idex_wb    <= '0;
      r_idex_dest  <= '0;
      r_exmem_mem  <= '0;
      r_exmem_wb   <= '0;
      r_exmem_dest <= '0;
      r_memwb_wb   <= '0;
      r_memwb_dest <= '0;
    end else begin
      if (w_stall) begin
        r_idex_ex   <= '0;
        r_idex_mem  <= '0;
        r_idex_wb   <= '0;
        r_idex_dest <= '0;
      end else begin
        r_idex_ex   <= w_dec_ex;
        r_idex_mem  <= w_dec_mem;
        r_idex_wb   <= w_dec_wb;
        r_idex_dest <= w_dest;
      end
      r_exmem_mem  <= r_idex_mem;
      r_exmem_wb   <= r_idex_wb;
      r_exmem_dest <= r_idex_dest;
      r_memwb_wb   <= r_exmem_wb;
      r_memwb_dest <= r_exmem_dest;
    end
  end

`ifdef CTRL_MULT_EN
  // Multiply occupancy: load on an issued mult, then count down to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_cnt <= '0;
    end else if (w_is_mult && !w_stall) begin
      r_mul_cnt <= MUL_CW'(MUL_LAT - 1);
    end else if (r_mul_cnt != '0) begin
      r_mul_cnt <= r_mul_cnt - MUL_CW'(1);
    end
  end
`endif

  assign ex_alu_src    = r_idex_ex.alu_src;
  assign ex_reg_dst    = r_idex_ex.reg_dst;
  assign ex_alu_op     = ALUOP_W'(r_idex_ex.alu_op);
  assign mem_read      = r_exmem_mem.mem_read;
  assign mem_write     = r_exmem_mem.mem_write;
  assign wb_reg_write  = r_memwb_wb.reg_write;
  assign wb_mem_to_reg = r_memwb_wb.mem_to_reg;
  assign wb_ra_write   = r_memwb_wb.ra_write;
  assign wb_dest       = r_memwb_dest;

endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
- Successor to the combinational MIPS main decoder. Decodes the ID-stage opcode/funct and carries the EX/MEM/WB control bundles through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use and branch-operand hazards; issues stall, bubble and flush.
- Resolves PC selection for beq/bne/j/jal/jr/jalr in ID.
- Sits between the IF/ID register and the datapath stage registers of the 5-stage core.

Parameters:
- REG_AW, 5, register-address width.
- ALUOP_W, 2, ALUOp width (minimum 2).
- MUL_LAT, 4, multiply occupancy in cycles (2..15); used only with CTRL_MULT_EN.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_opcode  in  6  instruction[31:26].
- id_funct  in  6  instruction[5:0].
- id_rs, id_rt, id_rd  in  REG_AW each  ID source and destination fields.
- id_eq  in  1  ID comparator result (rs==rt).
- pc_write  out  1  PC enable; 0 during stall.
- ifid_write  out  1  IF/ID enable; 0 during stall.
- if_flush  out  1  clear IF/ID.
- pc_sel  out  2  0 = PC+4, 1 = branch target, 2 = jump immediate, 3 = register (jr/jalr).
- ex_alu_src, ex_reg_dst  out  1 each  ID/EX control.
- ex_alu_op  out  ALUOP_W  ID/EX control.
- mem_read, mem_write  out  1 each  EX/MEM control.
- wb_reg_write, wb_mem_to_reg, wb_ra_write  out  1 each  MEM/WB control.
- wb_dest  out  REG_AW  MEM/WB destination register (31 when ra_write).

Behaviour:
- Reset: all stage registers clear to the bubble (all control 0, dest 0). Outputs then read pc_write=1, ifid_write=1, if_flush=0, pc_sel=0.
- Decode (combinational, ID):
  - R-type (op 0): alu_op=10, reg_dst=1, reg_write=1.
  - funct 08 (jr): pc_sel=3, no write.
  - funct 09 (jalr): pc_sel=3, ra_write=1, reg_write=1.
  - lw (23): alu_src=1, alu_op=00, mem_read=1, mem_to_reg=1, reg_write=1.
  - sw (2b): alu_src=1, alu_op=00, mem_write=1.
  - beq (04) / bne (05): alu_op=01; taken when id_eq (beq) or !id_eq (bne) gives pc_sel=1.
  - j (02): pc_sel=2.
  - jal (03): pc_sel=2, ra_write=1, reg_write=1.
  - All other opcodes: immediate ALU, alu_src=1, alu_op=11, reg_write=1.
- Destination: dest = ra_write ? 31 : reg_dst ? rd : rt. A dest of 0 never triggers a hazard.
- Stall conditions (any one):
  - a) EX holds a load whose dest equals id_rs or id_rt.
  - b) ID is beq/bne and EX reg_write dest matches rs or rt.
  - c) ID is beq/bne and MEM holds a load whose dest matches rs or rt.
  - d) ID is jr/jalr and EX reg_write dest, or MEM load dest, matches rs.
- During a stall:
  - pc_write=0, ifid_write=0, if_flush=0, pc_sel=0.
  - ID/EX loads the bubble.
  - EX/MEM and MEM/WB advance normally.
  - A stall lasts exactly as long as its condition holds: 1 cycle for (a), (b) and (d) via EX; 1 cycle for (c).
- No stall and pc_sel≠0: if_flush=1 for one cycle and the control transfer is committed. The branch/jump itself enters ID/EX with its decoded controls.
- Registers advance every cycle; there is no global hold input.
- Latency: ID decode appears on ex_* next cycle, mem_* +2, wb_* +3.
- Simultaneous stall and redirect: stall wins; redirect re-evaluates next cycle.
- Reset mid-operation clears all in-flight control immediately (asynchronously).

Optional Feature:
- CTRL_MULT_EN defined:
  - R-type funct 18 (mult) loads a down-counter with MUL_LAT-1 and writes HI/LO; no GPR write.
  - While the counter is nonzero, an ID-stage mfhi/mflo (funct 10/12) stalls with the same rules as other stalls.
  - A new mult while busy also stalls.
  - The counter decrements each cycle, saturates at 0, and resets to 0.
- CTRL_MULT_EN undefined: funct 18/10/12 decode as generic R-type; no counter is present.

Decomposition:
- Package ctrl_pkg holds:
  - opcode/funct localparams (OP_RTYPE, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_LW, OP_SW, FN_JR, FN_JALR, FN_MULT, FN_MFHI, FN_MFLO);
  - ALUOp codes;
  - pc_sel codes;
  - packed struct types ex_ctrl_t, mem_ctrl_t, wb_ctrl_t.
- One sub-module, ctrl_decode: the pure combinational decoder. The top holds the stage registers, the hazard logic and the optional mult counter.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all ex_/mem_/wb_ outputs 0, pc_write=1, pc_sel=0. Release; feed lw -> ex_alu_src=1 next cycle, mem_read=1 at +2, wb_mem_to_reg=1 at +3.
- Load-use: lw rt=8, then add rs=8 -> one cycle with pc_write=0, ifid_write=0 and ex_* zero; the add reaches EX one cycle later.
- Branch: beq, id_eq=1, no hazard -> pc_sel=1, if_flush=1 for one cycle. bne, id_eq=1 -> pc_sel=0, if_flush=0.
- Branch hazard: addi rt=9, then beq rs=9 -> 1 stall, then pc_sel=1. lw rt=9, nop, beq rt=9 -> 1 stall from rule (c).
- jal: -> pc_sel=2, flush; wb_ra_write=1 and wb_dest=31 three cycles later. jalr rs=4 right after addi rt=4 -> 1 stall, then pc_sel=3.
- With CTRL_MULT_EN and MUL_LAT=4: mult then mflo -> mflo stalls 3 cycles. Asserting rst_n=0 mid-count clears the stall the same cycle.
